// File: rtl/intra_ctx_buffer_if.sv
// rtl/intra_ctx_buffer_if.sv - fetch/update handshake and context bus for intra_ctx_buffer
interface intra_ctx_buffer_if;
   logic          frame_start;
   logic          fetch_start;
   logic [9:0]    fetch_x;
   logic [9:0]    fetch_y;
   logic          upd_start;
   logic [9:0]    upd_x;
   logic [9:0]    upd_y;
   logic [2047:0] rec;
   logic [127:0]  top;
   logic [127:0]  left;
   logic [7:0]    top_left;
   logic          ctx_valid;
   logic          upd_done;
   logic          busy;

   modport master (
      output frame_start, fetch_start, fetch_x, fetch_y,
      output upd_start, upd_x, upd_y, rec,
      input  top, left, top_left, ctx_valid, upd_done, busy
   );

   modport slave (
      input  frame_start, fetch_start, fetch_x, fetch_y,
      input  upd_start, upd_x, upd_y, rec,
      output top, left, top_left, ctx_valid, upd_done, busy
   );
endinterface

// File: rtl/intra_ctx_buffer.sv
// rtl/intra_ctx_buffer.sv - 16x16 luma intra neighbour context (line memory, left column, corner)
// Top rows live in a per-column line memory; left column and corner are carried in registers.
module intra_ctx_buffer #(
   parameter int BLOCK_SIZE = 16,
   parameter int MAX_MB_W   = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   intra_ctx_buffer_if.slave  bus
);
   localparam int AW   = (MAX_MB_W > 1) ? $clog2(MAX_MB_W) : 1;
   localparam int LW   = BLOCK_SIZE * 8;
   localparam int RECW = BLOCK_SIZE * BLOCK_SIZE * 8;
   localparam logic [10:0]   MAX_X   = 11'(MAX_MB_W);
   localparam logic [LW-1:0] ROW_127 = {BLOCK_SIZE{8'd127}};
   localparam logic [LW-1:0] COL_129 = {BLOCK_SIZE{8'd129}};

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_FOUT, S_URD, S_UWR} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [9:0]      f_x;
   logic [9:0]      f_y;
   logic [9:0]      u_x;
   logic [9:0]      u_y;
   logic            pend_fetch;
   logic [LW-1:0]   rec_bot;
   logic [LW-1:0]   rec_right;
   logic [LW-1:0]   rec_right_in;
   logic [LW-1:0]   left_reg;
   logic [7:0]      tl_reg;
   logic [LW-1:0]   top_hold;
   logic [LW-1:0]   left_hold;
   logic [7:0]      tl_hold;
   logic            upd_done_q;
   logic [LW-1:0]   mem [MAX_MB_W];
   logic [LW-1:0]   mem_rd_q;
   logic [AW-1:0]   u_addr;
   logic [AW-1:0]   f_addr;
   logic [AW-1:0]   rd_addr;
   logic            u_in_range;
   logic            f_in_range;
   logic            mem_we;
   logic [LW-1:0]   top_calc;
   logic [LW-1:0]   left_calc;
   logic [7:0]      tl_calc;

   assign u_addr     = u_x[AW-1:0];
   assign f_addr     = f_x[AW-1:0];
   assign u_in_range = ({1'b0, u_x} < MAX_X);
   assign f_in_range = ({1'b0, f_x} < MAX_X);
   assign rd_addr    = (state == S_URD) ? u_addr : f_addr;
   assign mem_we     = (state == S_UWR) && u_in_range;

   // Right-most pixel of each reconstructed row becomes the next block's left column.
   always_comb begin
      rec_right_in = '0;
      for (int r = 0; r < BLOCK_SIZE; r++) begin
         rec_right_in[r*8 +: 8] = bus.rec[(r*BLOCK_SIZE + BLOCK_SIZE - 1)*8 +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (bus.upd_start) begin
               state_nxt = S_URD;
            end else if (bus.fetch_start || pend_fetch) begin
               state_nxt = S_FETCH;
            end
         end
         S_FETCH: state_nxt = S_FOUT;
         S_FOUT:  state_nxt = S_IDLE;
         S_URD:   state_nxt = S_UWR;
         S_UWR:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_x        <= '0;
         f_y        <= '0;
         u_x        <= '0;
         u_y        <= '0;
         pend_fetch <= 1'b0;
         rec_bot    <= '0;
         rec_right  <= '0;
         left_reg   <= COL_129;
         tl_reg     <= 8'd127;
         top_hold   <= '0;
         left_hold  <= '0;
         tl_hold    <= '0;
         upd_done_q <= 1'b0;
      end else begin
         upd_done_q <= (state == S_UWR);
         if (state == S_IDLE) begin
            if (bus.frame_start) begin
               left_reg <= COL_129;
               tl_reg   <= 8'd127;
            end
            if (bus.fetch_start) begin
               f_x <= bus.fetch_x;
               f_y <= bus.fetch_y;
            end
            if (bus.upd_start) begin
               u_x        <= bus.upd_x;
               u_y        <= bus.upd_y;
               rec_bot    <= bus.rec[RECW-1 -: LW];
               rec_right  <= rec_right_in;
               pend_fetch <= pend_fetch | bus.fetch_start;
            end else if (bus.fetch_start || pend_fetch) begin
               pend_fetch <= 1'b0;
            end
         end
         // Corner for (x+1,y) is the old bottom-right pixel of column x, taken before the overwrite.
         if (state == S_UWR) begin
            tl_reg   <= (u_y != 10'd0) ? mem_rd_q[LW-1 -: 8] : 8'd127;
            left_reg <= rec_right;
         end
         if (state == S_FOUT) begin
            top_hold  <= top_calc;
            left_hold <= left_calc;
            tl_hold   <= tl_calc;
         end
      end
   end

   // Line memory: not reset, single synchronous read port shared by fetch and update.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[u_addr] <= rec_bot;
      end
      mem_rd_q <= mem[rd_addr];
   end

   always_comb begin
      top_calc  = (f_y == 10'd0 || !f_in_range) ? ROW_127 : mem_rd_q;
      left_calc = (f_x == 10'd0) ? COL_129 : left_reg;
      if (f_y == 10'd0) begin
         tl_calc = 8'd127;
      end else if (f_x == 10'd0) begin
         tl_calc = 8'd129;
      end else begin
         tl_calc = tl_reg;
      end
   end

   always_comb begin
      bus.ctx_valid = (state == S_FOUT);
      bus.busy      = (state != S_IDLE);
      bus.upd_done  = upd_done_q;
      bus.top       = (state == S_FOUT) ? top_calc  : top_hold;
      bus.left      = (state == S_FOUT) ? left_calc : left_hold;
      bus.top_left  = (state == S_FOUT) ? tl_calc   : tl_hold;
   end
endmodule

// File: tb/tb_intra_ctx_buffer.sv
// tb/tb_intra_ctx_buffer.sv - scoreboard bench for intra_ctx_buffer
module tb_intra_ctx_buffer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      bit           is_upd;
      int           cyc;
      logic [127:0] top;
      logic [127:0] left;
      logic [7:0]   tl;
   } exp_t;

   exp_t sb[$];

   intra_ctx_buffer_if bus();

   intra_ctx_buffer #(.BLOCK_SIZE(16), .MAX_MB_W(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] fill(input logic [7:0] b);
      return {16{b}};
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.ctx_valid) begin
         if (sb.size() == 0 || sb[0].is_upd) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ctx_valid cycle=%0d required=none", cyc);
         end else begin
            e = sb.pop_front();
            chk("ctx_top", bus.top, e.top);
            chk("ctx_left", bus.left, e.left);
            chk("ctx_top_left", 128'(bus.top_left), 128'(e.tl));
            chk("ctx_latency", 128'(cyc), 128'(e.cyc));
         end
      end
      if (rst_n && bus.upd_done) begin
         if (sb.size() == 0 || !sb[0].is_upd) begin
            checks++;
            errors++;
            $display("FAIL unexpected_upd_done cycle=%0d required=none", cyc);
         end else begin
            e = sb.pop_front();
            chk("upd_latency", 128'(cyc), 128'(e.cyc));
         end
      end
   end

   task automatic wait_idle();
      int k;
      for (k = 0; k < 60; k++) begin
         if (sb.size() == 0 && !bus.busy) break;
         @(posedge clk); #1;
      end
      checks++;
      if (k == 60) begin
         errors++;
         $display("FAIL wait_idle_timeout pending=%0d busy=%0d required=0/0", sb.size(), bus.busy);
         sb.delete();
      end
   endtask

   task automatic pulse_frame();
      bus.frame_start = 1'b1;
      @(posedge clk); #1;
      bus.frame_start = 1'b0;
   endtask

   // Called #1 after a clock edge with the block idle.
   task automatic issue(input bit f, input int fx, input int fy,
                        input logic [127:0] et, input logic [127:0] el, input logic [7:0] etl,
                        input bit u, input int ux, input int uy, input logic [2047:0] r);
      exp_t e;
      int   n;
      n = cyc;
      if (u) begin
         e.is_upd = 1'b1; e.cyc = n + 3; e.top = '0; e.left = '0; e.tl = '0;
         sb.push_back(e);
      end
      if (f) begin
         e.is_upd = 1'b0; e.cyc = u ? n + 5 : n + 2; e.top = et; e.left = el; e.tl = etl;
         sb.push_back(e);
      end
      bus.fetch_start = f;
      bus.fetch_x     = 10'(fx);
      bus.fetch_y     = 10'(fy);
      bus.upd_start   = u;
      bus.upd_x       = 10'(ux);
      bus.upd_y       = 10'(uy);
      bus.rec         = r;
      @(posedge clk); #1;
      bus.fetch_start = 1'b0;
      bus.upd_start   = 1'b0;
      bus.fetch_x     = 10'd513;
      bus.fetch_y     = 10'd777;
      bus.upd_x       = 10'd514;
      bus.upd_y       = 10'd778;
      bus.rec         = {256{8'hEE}};
      wait_idle();
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout cycle=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [2047:0] r0, r1, r2, rz;
      logic [127:0]  l0, t5, t7, l8;
      exp_t          e;
      int            n;

      for (int k = 0; k < 256; k++) begin
         r0[k*8 +: 8] = 8'(k);
         r1[k*8 +: 8] = 8'(255 - k);
         r2[k*8 +: 8] = 8'(8'h60 + (k >> 4));
      end
      rz = '0;
      for (int i = 0; i < 16; i++) begin
         l0[i*8 +: 8] = 8'(i*16 + 15);
         t5[i*8 +: 8] = 8'(240 + i);
         t7[i*8 +: 8] = 8'(15 - i);
         l8[i*8 +: 8] = 8'(8'h60 + i);
      end

      bus.frame_start = 1'b0;
      bus.fetch_start = 1'b0;
      bus.upd_start   = 1'b0;
      bus.fetch_x = '0; bus.fetch_y = '0;
      bus.upd_x = '0;   bus.upd_y = '0;
      bus.rec = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_top", bus.top, 128'd0);
      chk("reset_left", bus.left, 128'd0);
      chk("reset_top_left", 128'(bus.top_left), 128'd0);
      chk("reset_ctx_valid", 128'(bus.ctx_valid), 128'd0);
      chk("reset_upd_done", 128'(bus.upd_done), 128'd0);
      chk("reset_busy", 128'(bus.busy), 128'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      pulse_frame();

      issue(1, 0, 0, fill(8'd127), fill(8'd129), 8'd127, 0, 0, 0, rz);
      issue(0, 0, 0, '0, '0, '0, 1, 0, 0, r0);
      issue(1, 1, 0, fill(8'd127), l0, 8'd127, 0, 0, 0, rz);
      issue(0, 0, 0, '0, '0, '0, 1, 1, 0, r1);
      issue(1, 0, 1, t5, fill(8'd129), 8'd129, 0, 0, 0, rz);
      issue(0, 0, 0, '0, '0, '0, 1, 0, 1, {256{8'h50}});
      issue(1, 1, 1, t7, fill(8'h50), 8'd255, 0, 0, 0, rz);
      // Simultaneous update and fetch: fetch must observe the just-committed column 1.
      issue(1, 1, 2, fill(8'h6F), l8, 8'd0, 1, 1, 1, r2);
      issue(1, 0, 2, fill(8'h50), fill(8'd129), 8'd129, 0, 0, 0, rz);

      n = cyc;
      e.is_upd = 1'b1; e.cyc = n + 3; e.top = '0; e.left = '0; e.tl = '0;
      sb.push_back(e);
      bus.upd_start = 1'b1; bus.upd_x = 10'd0; bus.upd_y = 10'd2; bus.rec = {256{8'h11}};
      @(posedge clk); #1;
      bus.upd_start = 1'b0;
      bus.fetch_start = 1'b1; bus.fetch_x = 10'd5; bus.fetch_y = 10'd5;
      chk("busy_during_update", 128'(bus.busy), 128'd1);
      @(posedge clk); #1;
      bus.fetch_start = 1'b0;
      wait_idle();
      repeat (6) @(posedge clk);
      #1;

      pulse_frame();
      issue(1, 1, 1, fill(8'h6F), fill(8'd129), 8'd127, 0, 0, 0, rz);
      issue(0, 0, 0, '0, '0, '0, 1, 65, 0, {256{8'h22}});
      issue(1, 65, 1, fill(8'd127), fill(8'h22), 8'd127, 0, 0, 0, rz);
      issue(1, 1, 2, fill(8'h6F), fill(8'h22), 8'd127, 0, 0, 0, rz);

      bus.upd_start = 1'b1; bus.upd_x = 10'd0; bus.upd_y = 10'd3; bus.rec = {256{8'h33}};
      @(posedge clk); #1;
      bus.upd_start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst_uwr_top", bus.top, 128'd0);
      chk("rst_uwr_left", bus.left, 128'd0);
      chk("rst_uwr_top_left", 128'(bus.top_left), 128'd0);
      chk("rst_uwr_busy", 128'(bus.busy), 128'd0);
      chk("rst_uwr_upd_done", 128'(bus.upd_done), 128'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      issue(1, 0, 0, fill(8'd127), fill(8'd129), 8'd127, 0, 0, 0, rz);

      repeat (4) @(posedge clk);
      #1;
      chk("scoreboard_empty", 128'(sb.size()), 128'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
